// File: rtl/uivtm.sv
// Video timing meter: measures active width/lines, line period and lines per frame
// from a vs/hs/de stream, checks frame-to-frame stability and expected geometry.
module uivtm #(
    parameter int CNT_W       = 12,
    parameter int LOCK_FRAMES = 4,
    parameter bit VS_POL      = 1'b1
) (
    input  logic             vtm_clk_i,
    input  logic             vtm_rstn_i,
    input  logic             vtm_vs_i,
    input  logic             vtm_hs_i,
    input  logic             vtm_de_i,
    input  logic [CNT_W-1:0] exp_hact_i,
    input  logic [CNT_W-1:0] exp_vact_i,
    input  logic             err_clr_i,
    output logic [CNT_W-1:0] h_act_o,
    output logic [CNT_W-1:0] v_act_o,
    output logic [CNT_W-1:0] h_total_o,
    output logic [CNT_W-1:0] v_total_o,
    output logic             frame_done_o,
    output logic             locked_o,
    output logic [3:0]       err_o
);

    localparam logic [CNT_W-1:0] ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CMAX   = {CNT_W{1'b1}};
    localparam logic [3:0]       LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic [0:0] {ST_SEEK = 1'b0, ST_MEASURE = 1'b1} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CMAX) ? v : v + ONE;
    endfunction

    state_t           r_state, w_state_nxt;
    logic             r_vs, r_hs, r_de;
    logic [CNT_W-1:0] r_hcnt, r_run, r_htot_acc, r_vtot, r_vact, r_width;
    logic             r_wvalid, r_frame_bad, r_have_prev;
    logic [CNT_W-1:0] r_h_act, r_v_act, r_h_total, r_v_total;
    logic             r_frame_done, r_locked;
    logic [3:0]       r_lock_cnt, w_lock_nxt;
    logic [3:0]       r_err, w_err_set;

    logic             w_fs, w_le, w_df;
    logic             w_meas, w_commit;
    logic             w_sat, w_wid_mis, w_frame_bad, w_f2f_mis, w_exp_mis;
    logic [CNT_W-1:0] w_hcnt_nxt, w_run_nxt, w_width_fin, w_vact_fin;

    assign w_fs = (vtm_vs_i == VS_POL) && (r_vs != VS_POL);
    assign w_le = vtm_hs_i && !r_hs;
    assign w_df = r_de && !vtm_de_i;

    assign h_act_o      = r_h_act;
    assign v_act_o      = r_v_act;
    assign h_total_o    = r_h_total;
    assign v_total_o    = r_v_total;
    assign frame_done_o = r_frame_done;
    assign locked_o     = r_locked;
    assign err_o        = r_err;

    // Next-state logic: wait for the first frame start, then measure forever.
    always_comb begin
        w_state_nxt = r_state;
        w_meas      = (r_state == ST_MEASURE);
        w_commit    = 1'b0;
        case (r_state)
            ST_SEEK: begin
                if (w_fs) w_state_nxt = ST_MEASURE;
                else      w_state_nxt = ST_SEEK;
            end
            ST_MEASURE: begin
                w_state_nxt = ST_MEASURE;
                w_commit    = w_fs;
            end
            default: w_state_nxt = ST_SEEK;
        endcase
    end

    // Frame-end values include a DF in the FS cycle; an LE in that cycle belongs to the new frame.
    always_comb begin
        w_hcnt_nxt  = w_le ? ONE : sat_inc(r_hcnt);
        w_run_nxt   = vtm_de_i ? sat_inc(r_run) : ZERO;
        w_sat       = w_meas && ((!w_le && (r_hcnt == CMAX)) ||
                                 (vtm_de_i && (r_run == CMAX)) ||
                                 (w_df && (r_vact == CMAX)) ||
                                 (w_le && !w_fs && (r_vtot == CMAX)));
        w_wid_mis   = w_meas && w_df && r_wvalid && (r_run != r_width);
        w_width_fin = (w_df && !r_wvalid) ? r_run : r_width;
        w_vact_fin  = w_df ? sat_inc(r_vact) : r_vact;
        w_frame_bad = r_frame_bad || w_wid_mis || w_sat;
        w_f2f_mis   = (w_width_fin != r_h_act) || (w_vact_fin != r_v_act) ||
                      (r_htot_acc != r_h_total) || (r_vtot != r_v_total);
        w_exp_mis   = (w_width_fin != exp_hact_i) || (w_vact_fin != exp_vact_i);
        w_err_set   = {w_commit && w_exp_mis,
                       w_commit && r_have_prev && w_f2f_mis,
                       w_sat,
                       w_wid_mis};
        if (r_have_prev && !w_f2f_mis && !w_frame_bad) begin
            w_lock_nxt = (r_lock_cnt == LOCK_N) ? r_lock_cnt : r_lock_cnt + 4'd1;
        end else begin
            w_lock_nxt = 4'd0;
        end
    end

    // Input history for edge detection and FSM state.
    always_ff @(posedge vtm_clk_i or negedge vtm_rstn_i) begin
        if (!vtm_rstn_i) begin
            r_vs    <= 1'b0;
            r_hs    <= 1'b0;
            r_de    <= 1'b0;
            r_state <= ST_SEEK;
        end else begin
            r_vs    <= vtm_vs_i;
            r_hs    <= vtm_hs_i;
            r_de    <= vtm_de_i;
            r_state <= w_state_nxt;
        end
    end

    // Line clock counter and DE run length; both span frame boundaries.
    always_ff @(posedge vtm_clk_i or negedge vtm_rstn_i) begin
        if (!vtm_rstn_i) begin
            r_hcnt <= ZERO;
            r_run  <= ZERO;
        end else begin
            r_hcnt <= w_hcnt_nxt;
            r_run  <= w_run_nxt;
        end
    end

    // Per-frame accumulators, restarted on every frame start.
    always_ff @(posedge vtm_clk_i or negedge vtm_rstn_i) begin
        if (!vtm_rstn_i) begin
            r_htot_acc  <= ZERO;
            r_vtot      <= ZERO;
            r_vact      <= ZERO;
            r_width     <= ZERO;
            r_wvalid    <= 1'b0;
            r_frame_bad <= 1'b0;
        end else if (w_fs) begin
            r_htot_acc  <= w_le ? r_hcnt : ZERO;
            r_vtot      <= w_le ? ONE : ZERO;
            r_vact      <= ZERO;
            r_width     <= ZERO;
            r_wvalid    <= 1'b0;
            r_frame_bad <= 1'b0;
        end else if (w_meas) begin
            if (w_le) begin
                r_htot_acc <= r_hcnt;
                r_vtot     <= sat_inc(r_vtot);
            end
            if (w_df && !r_wvalid) begin
                r_width  <= r_run;
                r_wvalid <= 1'b1;
            end
            r_vact      <= w_vact_fin;
            r_frame_bad <= w_frame_bad;
        end
    end

    // Commit of measurements, frame pulse and lock tracking.
    always_ff @(posedge vtm_clk_i or negedge vtm_rstn_i) begin
        if (!vtm_rstn_i) begin
            r_h_act      <= ZERO;
            r_v_act      <= ZERO;
            r_h_total    <= ZERO;
            r_v_total    <= ZERO;
            r_frame_done <= 1'b0;
            r_have_prev  <= 1'b0;
            r_lock_cnt   <= 4'd0;
            r_locked     <= 1'b0;
        end else begin
            r_frame_done <= w_commit;
            if (w_commit) begin
                r_h_act     <= w_width_fin;
                r_v_act     <= w_vact_fin;
                r_h_total   <= r_htot_acc;
                r_v_total   <= r_vtot;
                r_have_prev <= 1'b1;
                r_lock_cnt  <= w_lock_nxt;
                r_locked    <= (w_lock_nxt == LOCK_N);
            end
        end
    end

    // Sticky error flags; a new event in the clear cycle survives the clear.
    always_ff @(posedge vtm_clk_i or negedge vtm_rstn_i) begin
        if (!vtm_rstn_i) begin
            r_err <= 4'b0000;
        end else begin
            r_err <= (err_clr_i ? 4'b0000 : r_err) | w_err_set;
        end
    end

endmodule

// File: doc/uivtm.md
Name: uivtm

Overview:
- Video timing meter/checker: the receiving end of the vs/hs/de timing interface that drives the test pattern generator.
- Samples an incoming vs/hs/de stream and measures the following per frame:
  - active width
  - active lines
  - line period
  - lines per frame
- Compares each frame against the previous frame and against expected values, and asserts lock after consecutive consistent frames.
- Sits on the video path after the TPG or the capture front end; used for bring-up and on-line link monitoring.

Parameters:
- CNT_W, 12, width of all measurement counters and outputs.
- LOCK_FRAMES, 4, consecutive consistent error-free frames required for lock (1..15).
- VS_POL, 1, active level of vs (1 = active-high, 0 = active-low).

Ports:
- vtm_clk_i  in  1  pixel clock
- vtm_rstn_i  in  1  asynchronous active-low reset
- vtm_vs_i  in  1  vertical sync, synchronous to vtm_clk_i
- vtm_hs_i  in  1  horizontal sync, synchronous; line boundary is its rising edge
- vtm_de_i  in  1  data enable, active-high
- exp_hact_i  in  CNT_W  expected active width (quasi-static)
- exp_vact_i  in  CNT_W  expected active lines (quasi-static)
- err_clr_i  in  1  single-cycle clear of sticky errors
- h_act_o  out  CNT_W  committed active width (DE cycles per line)
- v_act_o  out  CNT_W  committed active lines (DE runs per frame)
- h_total_o  out  CNT_W  committed line period in clocks
- v_total_o  out  CNT_W  committed hs rising edges per frame
- frame_done_o  out  1  one-cycle pulse on commit
- locked_o  out  1  timing stable
- err_o  out  4  sticky flags: [0] intra-frame width mismatch, [1] counter saturation, [2] frame-to-frame mismatch, [3] expected-value mismatch

Behaviour:
- Reset: the asynchronous assert clears all outputs to 0, all counters to 0, edge registers to 0, and the FSM to SEEK.
- Edge detection: each input is registered once; edges are taken from the current input vs the previous sample.
  - Frame start (FS): vs transitions to its VS_POL level.
  - Line edge (LE): hs rising.
  - DE fall (DF): de_r=1 and de_i=0.
- FSM SEEK: ignores all events until the first FS, then clears the frame accumulators and goes to MEASURE. No commit, no frame_done_o.
- FSM MEASURE, per-clock accumulation:
  - hcnt increments every clock. On LE, h_total_acc<=hcnt, then hcnt restarts at 1.
  - run increments while de_i=1. On DF:
    - the first DF of the frame stores width<=run;
    - a later run!=width sets err[0];
    - vact_acc increments.
  - vtot_acc increments on LE.
- FSM MEASURE, commit: on FS (the edge at clock N), outputs update at edge N+1 and frame_done_o pulses for exactly that cycle.
  - h_act_o<=width, v_act_o<=vact_acc, h_total_o<=h_total_acc, v_total_o<=vtot_acc.
  - Accumulators reset for the new frame.
- Simultaneous events in the FS cycle: DF belongs to the ending frame; LE belongs to the new frame (vtot_acc starts at 1).
- DE run spanning FS: the run is not split; it is attributed to the frame in which DF occurs.
- Saturation: every counter saturates at 2^CNT_W-1 and sets err[1]; it never wraps.
- Frame-to-frame check at commit: compare the four new values with the currently held outputs.
  - Any difference sets err[2].
  - The first commit after reset is never compared.
- Expected-value check at commit: width!=exp_hact_i or vact_acc!=exp_vact_i sets err[3].
- Lock counter (0..LOCK_FRAMES), updated at commit:
  - Increments when the frame matched the previous commit and had no err[0]/err[1] event this frame; otherwise it returns to 0.
  - locked_o=1 while counter==LOCK_FRAMES. It drops at the same edge as the failing commit.
  - err[3] does not affect lock.
- Sticky errors:
  - err_clr_i clears err_o.
  - Set wins over clear in the same cycle.
  - err_clr_i does not affect lock or measurements.
- Frames with zero DE runs commit h_act_o=0 and v_act_o=0; no error is flagged.

Test Plan:
- Stimulus: reset, then 6 frames of h_total=20, DE=12 per line (hs 2 clocks), v_total=10 lines, 6 active lines; exp=12/6, LOCK_FRAMES=4. Required response:
  - frame_done_o pulses one cycle after each FS except the first;
  - outputs read 12/6/20/10;
  - locked_o rises at the 5th commit;
  - err_o=0.
- Stimulus: in a locked stream, one line carries DE=11. Required response:
  - err[0] sets at that DF;
  - locked_o drops at that frame's commit;
  - re-lock occurs after 4 clean frames.
- Stimulus: change v_total from 10 to 11 mid-run. Required response:
  - err[2] set at the first 11-line commit;
  - v_total_o=11;
  - lock counter restarts.
- Stimulus: exp_hact_i=13 with a clean 12-wide stream. Required response:
  - err[3] set at every commit;
  - locked_o still asserts.
- Stimulus: CNT_W=4 with h_total=20. Required response: h_total_o=15 and err[1] set. Then assert err_clr_i together with a new saturation event: err[1] stays set.
- Stimulus: assert vtm_rstn_i low mid-frame. Required response:
  - all outputs 0 immediately;
  - after release, no frame_done_o until the second FS.
